count_sched: RTL and testbench

Round-robin scheduler that shares one down-counting timer among `NUM_REQ` requesters. Each requester presents a load value and holds a request. The block then:
- grants the timer to one requester at a time,
- loads and decrements the count,
- returns a one-cycle done pulse to the owner.

It sits between the control FSMs and the timer datapath. It replaces per-client countdown counters with one shared instance.

---
 rtl/count_sched_pkg.sv | 25 ++
 rtl/count_sched_rr_arbiter.sv | 41 ++++
 rtl/count_sched.sv | 170 +++++++++++++++++
 tb/tb_count_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// -----------------------------------------------------------------------------
// count_sched_pkg
// Shared types and defaults for the count_sched shared-timer scheduler.
//   state_t        : scheduler FSM states (IDLE, COUNT, DONE)
//   *_DEF          : default NUM_REQ / CNT_W / DEFAULT_LOAD parameter values
//   load_fits()    : static check that a load constant fits in the timer width
// -----------------------------------------------------------------------------
package count_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_REQ_DEF      = 4;
    localparam int CNT_W_DEF        = 4;
    localparam int DEFAULT_LOAD_DEF = 10;

    // True when 'value' is representable as an unsigned 'width'-bit number.
    function automatic bit load_fits(input int value, input int width);
        return (value >= 0) && (width >= 31 || value < (1 << width));
    endfunction

endpackage : count_sched_pkg

// File: rtl/count_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the lowest requester index at or above
// i_ptr wins, wrapping past NUM_REQ-1 back to 0.
// Ports:
//   i_req   [NUM_REQ] : level requests
//   i_ptr   [IDX_W]   : starting index for the search (must be < NUM_REQ)
//   o_gnt   [NUM_REQ] : one-hot winner, all zero when no request
//   o_idx   [IDX_W]   : encoded winner index (0 when no request)
//   o_valid           : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    always_comb begin
        int w_pos;
        // NOTE: every output gets a default before the search loop so no
        // path through this block leaves a value unassigned (no latches).
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_valid && i_req[w_pos]) begin
                o_valid       = 1'b1;
                o_gnt[w_pos]  = 1'b1;
                o_idx         = IDX_W'(w_pos);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/count_sched.sv
// -----------------------------------------------------------------------------
// count_sched
// Round-robin scheduler sharing one down-counting timer among NUM_REQ
// requesters. A granted requester's load value (or DEFAULT_LOAD when that
// value is 0) is counted down to 0, then a one-cycle done pulse goes back to
// the owner and the round-robin pointer advances past it.
//
// Optional feature: define COUNT_SCHED_PRESCALE_EN to build a free-running
// CNT_W-bit prescaler; the timer then decrements only when the prescaler is
// at its maximum. Without it the timer decrements every cycle.
//
// Ports:
//   clk        : clock, rising edge
//   areset_n   : asynchronous active-low reset
//   req        [NUM_REQ]       : level request per requester
//   load_val   [NUM_REQ*CNT_W] : requester i uses [i*CNT_W +: CNT_W]
//   gnt        [NUM_REQ]       : registered one-hot timer owner, 0 when idle
//   done       [NUM_REQ]       : registered one-cycle expiry pulse to owner
//   busy                       : registered, high whenever state != IDLE
//   cur_count  [CNT_W]         : current timer value
// -----------------------------------------------------------------------------
module count_sched
    import count_sched_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_LOAD = DEFAULT_LOAD_DEF
) (
    input  logic                     clk,
    input  logic                     areset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] load_val,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [CNT_W-1:0]         cur_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Elaboration-time parameter sanity checks.
    if (!load_fits(DEFAULT_LOAD, CNT_W)) begin : g_bad_default_load
        $error("count_sched: DEFAULT_LOAD does not fit in CNT_W bits");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("count_sched: NUM_REQ must be in 2..8");
    end

    state_t               r_state, w_next_state;
    logic [NUM_REQ-1:0]   r_gnt, w_next_gnt;
    logic [NUM_REQ-1:0]   r_done, w_next_done;
    logic                 r_busy, w_next_busy;
    logic [CNT_W-1:0]     r_count, w_next_count;
    logic [IDX_W-1:0]     r_ptr, w_next_ptr;
    logic [IDX_W-1:0]     r_owner, w_next_owner;

    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic [IDX_W-1:0]     w_arb_idx;
    logic                 w_arb_valid;
    logic [CNT_W-1:0]     w_load_raw;
    logic [CNT_W-1:0]     w_load_eff;
    logic                 w_dec_en;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_load_raw = load_val[int'(w_arb_idx)*CNT_W +: CNT_W];
    // A zero load would otherwise expire instantly; substitute the default.
    assign w_load_eff = (w_load_raw == '0) ? CNT_W'(DEFAULT_LOAD) : w_load_raw;

`ifdef COUNT_SCHED_PRESCALE_EN
    logic [CNT_W-1:0] r_prescale;

    // Free-running regardless of state, so the first decrement of a count
    // lands anywhere from 1 to 2^CNT_W cycles after the grant.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    assign w_dec_en = &r_prescale;
`else
    assign w_dec_en = 1'b1;
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_gnt   = r_gnt;
        w_next_done  = '0;
        w_next_count = r_count;
        w_next_ptr   = r_ptr;
        w_next_owner = r_owner;

        unique case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_next_state = COUNT;
                    w_next_gnt   = w_arb_gnt;
                    w_next_owner = w_arb_idx;
                    w_next_count = w_load_eff;
                end
            end
            COUNT: begin
                if (w_dec_en) begin
                    // The 1->0 step enters DONE on the same edge; the guard
                    // on <=1 also keeps the timer from ever wrapping.
                    if (r_count <= CNT_W'(1)) begin
                        w_next_state = DONE;
                        w_next_count = '0;
                        w_next_done  = r_gnt;
                    end else begin
                        w_next_count = r_count - 1'b1;
                    end
                end
            end
            DONE: begin
                w_next_state = IDLE;
                w_next_gnt   = '0;
                w_next_count = '0;
                w_next_ptr   = (r_owner == IDX_W'(NUM_REQ-1)) ? '0 : r_owner + 1'b1;
            end
            default: begin
                w_next_state = IDLE;
                w_next_gnt   = '0;
                w_next_count = '0;
            end
        endcase

        w_next_busy = (w_next_state != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_next_state;
            r_gnt   <= w_next_gnt;
            r_done  <= w_next_done;
            r_busy  <= w_next_busy;
            r_count <= w_next_count;
            r_ptr   <= w_next_ptr;
            r_owner <= w_next_owner;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign busy      = r_busy;
    assign cur_count = r_count;

endmodule : count_sched

// File: tb/tb_count_sched.sv
// -----------------------------------------------------------------------------
// tb_count_sched
// Directed self-checking bench for count_sched (NUM_REQ=4, CNT_W=4,
// DEFAULT_LOAD=10). Exact-latency scenarios apply to the default build; the
// COUNT_SCHED_PRESCALE_EN build runs the prescaled-latency scenario instead.
// -----------------------------------------------------------------------------
module tb_count_sched;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 4;

    logic                     clk;
    logic                     areset_n;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*CNT_W-1:0] load_val;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [CNT_W-1:0]         cur_count;

    int n_checks = 0;
    int n_errors = 0;

    count_sched #(
        .NUM_REQ      (NUM_REQ),
        .CNT_W        (CNT_W),
        .DEFAULT_LOAD (10)
    ) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .req       (req),
        .load_val  (load_val),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .cur_count (cur_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and land just after the edge: outputs are stable and
    // newly driven inputs are sampled on the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input int idx, input logic [CNT_W-1:0] v);
        load_val[idx*CNT_W +: CNT_W] = v;
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        #2;
        areset_n = 1'b1;
        tick();
    endtask

    // Ticks until done is nonzero, returning the number of ticks taken.
    task automatic wait_done(input string tag, input int max_cycles, output int cycles);
        cycles = 0;
        while (done == '0 && cycles < max_cycles) begin
            tick();
            cycles++;
        end
        check(tag, (done != '0), 1);
    endtask

    initial begin
        int n;
        int busy_cycles;

        areset_n = 1'b0;
        req      = '0;
        load_val = '0;

        // Reset state, observed while reset is held.
        #2;
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_count", cur_count, 0);
        tick();
        areset_n = 1'b1;

        // Idle with no requests for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_busy", busy, 0);
            check("idle_count", cur_count, 0);
        end

`ifdef COUNT_SCHED_PRESCALE_EN
        // Load 2: two decrements, first one 1..16 cycles in, second 16 later.
        do_reset();
        set_load(0, 4'd2);
        req = 4'b0001;
        tick();
        check("pre_gnt", gnt, 4'b0001);
        check("pre_load", cur_count, 2);
        req = '0;
        wait_done("pre_done_seen", 40, n);
        check("pre_latency_in_17_32", (n >= 17 && n <= 32), 1);
        check("pre_done_owner", done, 4'b0001);
        check("pre_done_count", cur_count, 0);
        tick();
        check("pre_gnt_clear", gnt, 0);
        check("pre_busy_clear", busy, 0);
`else
        // Single request, load 3: counts 3,2,1,0(done), then idle.
        set_load(2, 4'd3);
        req = 4'b0100;
        busy_cycles = 0;
        tick();
        check("single_gnt", gnt, 4'b0100);
        check("single_load", cur_count, 3);
        check("single_done_early", done, 0);
        busy_cycles += int'(busy);
        tick();
        check("single_cnt2", cur_count, 2);
        busy_cycles += int'(busy);
        tick();
        check("single_cnt1", cur_count, 1);
        check("single_no_done", done, 0);
        busy_cycles += int'(busy);
        tick();
        check("single_cnt0", cur_count, 0);
        check("single_done", done, 4'b0100);
        check("single_gnt_held", gnt, 4'b0100);
        busy_cycles += int'(busy);
        req = '0;
        tick();
        check("single_gnt_clear", gnt, 0);
        check("single_done_clear", done, 0);
        check("single_busy_clear", busy, 0);
        // busy rises with the grant and falls one cycle after done.
        check("single_busy_len", busy_cycles, 4);

        // Zero load substitutes DEFAULT_LOAD = 10.
        set_load(0, 4'd0);
        req = 4'b0001;
        tick();
        check("zero_gnt", gnt, 4'b0001);
        check("zero_load", cur_count, 10);
        wait_done("zero_done_seen", 20, n);
        check("zero_latency", n, 10);
        check("zero_done_owner", done, 4'b0001);
        req = '0;
        tick();
        check("zero_gnt_clear", gnt, 0);

        // Round-robin with all four requesting, loads 1: grants 0,1,2,3,0
        // at a 3-cycle spacing (grant, done, idle).
        do_reset();
        load_val = 16'h1111;
        req      = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            logic [NUM_REQ-1:0] exp_oh;
            exp_oh = 4'b0001 << (g % NUM_REQ);
            check("rr_gnt", gnt, exp_oh);
            check("rr_count1", cur_count, 1);
            check("rr_no_done_at_gnt", done, 0);
            tick();
            check("rr_done_owner", done, exp_oh);
            check("rr_done_count", cur_count, 0);
            if (g == 4) req = '0;
            tick();
            check("rr_idle_gnt", gnt, 0);
            check("rr_idle_busy", busy, 0);
            tick();
        end
        check("rr_stop", gnt, 0);

        // Pointer now sits at 1. Grant requester 2 with load 9, drop its req
        // (must not abort), then reset while the count shows 5.
        set_load(2, 4'd9);
        req = 4'b0100;
        tick();
        check("mid_gnt", gnt, 4'b0100);
        check("mid_load", cur_count, 9);
        req = '0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_count5", cur_count, 5);
        check("mid_gnt_kept", gnt, 4'b0100);
        #2;
        areset_n = 1'b0;
        #1;
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", cur_count, 0);
        @(posedge clk);
        #1;
        check("mid_rst_no_done", done, 0);
        @(negedge clk);
        areset_n = 1'b1;
        set_load(0, 4'd1);
        set_load(1, 4'd1);
        req = 4'b0011;
        tick();
        // Pointer reset to 0, so requester 0 beats requester 1.
        check("mid_ptr_restart", gnt, 4'b0001);
        req = '0;
        tick();
        check("mid_after_done", done, 4'b0001);
        tick();
        check("mid_after_idle", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_count_sched
